// File: rtl/ss_freq_loop_if.sv
// Control/status bundle between the FLL core and its surroundings (DCO driver, config, monitor).
// Pure wiring, no latency.
// No backpressure: every signal is a level or a one-cycle pulse sampled on ref_clk.
interface ss_freq_loop_if #(
  parameter int CNT_W  = 12,
  parameter int CODE_W = 8
);
  logic                    enable;
  logic                    dco_pulse;
  logic [CNT_W-1:0]        target_cnt;
  logic [CNT_W-1:0]        lock_tol;
  logic                    ss_en;
  logic [7:0]              ss_depth;
  logic [CODE_W-1:0]       dco_code;
  logic [CNT_W-1:0]        meas_cnt;
  logic                    meas_valid;
  logic                    freq_update;
  logic                    freq_incr_decr;
  logic                    fll_locked;
  logic signed [CNT_W:0]   ss_offset;

  // Controller / environment side
  modport master (
    output enable, dco_pulse, target_cnt, lock_tol, ss_en, ss_depth,
    input  dco_code, meas_cnt, meas_valid, freq_update, freq_incr_decr, fll_locked, ss_offset
  );

  // FLL core side
  modport slave (
    input  enable, dco_pulse, target_cnt, lock_tol, ss_en, ss_depth,
    output dco_code, meas_cnt, meas_valid, freq_update, freq_incr_decr, fll_locked, ss_offset
  );
endinterface

// File: rtl/ss_freq_loop.sv
// Frequency-locked loop: counts divided-DCO pulses per window, steers dco_code toward target + ss_offset.
// One iteration = WIN_LEN+2 ref_clk cycles (MEASURE x WIN_LEN, COMPARE, UPDATE); all outputs registered.
// No backpressure: dco_pulse is sampled every MEASURE cycle; enable=0 parks the loop in IDLE.
module ss_freq_loop #(
  parameter int CNT_W       = 12,
  parameter int CODE_W      = 8,
  parameter int WIN_LEN     = 256,
  parameter int LOCK_WINS   = 4,
  parameter int COARSE_THR  = 16,
  parameter int COARSE_STEP = 8,
  parameter int CODE_INIT   = 2 ** (CODE_W - 1)
) (
  input logic           ref_clk,
  input logic           reset,
  ss_freq_loop_if.slave bus
);

  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int LOCK_W = $clog2(LOCK_WINS + 1);
  localparam int DIFF_W = CNT_W + 2;
  localparam int SW     = CODE_W + 2;

  localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [LOCK_W-1:0]    LOCK_FULL = LOCK_W'(LOCK_WINS);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
  localparam logic [DIFF_W-1:0]    THR       = DIFF_W'(COARSE_THR);
  localparam logic signed [SW-1:0] STEP_C    = SW'(COARSE_STEP);
  localparam logic signed [SW-1:0] STEP_F    = SW'(1);
  localparam logic signed [SW-1:0] CODE_MAX  = SW'((2 ** CODE_W) - 1);
  localparam logic [CODE_W-1:0]    CODE_RST  = CODE_W'(CODE_INIT);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_COMPARE, S_UPDATE} state_t;

  state_t                   state_q;
  logic [WIN_W-1:0]         win_cnt_q;
  logic [CNT_W-1:0]         pulse_cnt_q;
  logic signed [DIFF_W-1:0] target_eff_q;
  logic signed [DIFF_W-1:0] diff_q;
  logic                     in_range_q;
  logic [LOCK_W-1:0]        lock_cnt_q;
  logic                     fll_locked_q;
  logic [CODE_W-1:0]        dco_code_q;
  logic [CNT_W-1:0]         meas_cnt_q;
  logic                     meas_valid_q;
  logic                     freq_update_q;
  logic                     freq_incr_decr_q;
  logic signed [CNT_W:0]    ss_offset_q;
  logic                     ss_dn_q;

  logic [CNT_W-1:0]         pulse_cnt_d;
  logic signed [DIFF_W-1:0] diff_c;
  logic [DIFF_W-1:0]        abs_c;
  logic                     in_range_c;
  logic [LOCK_W-1:0]        lock_cnt_d;

  logic [DIFF_W-1:0]        abs_q;
  logic signed [SW-1:0]     step_c;
  logic signed [SW-1:0]     code_ext;
  logic signed [SW-1:0]     code_sum;
  logic [CODE_W-1:0]        code_d;
  logic                     code_chg;
  logic signed [CNT_W:0]    depth_s;
  logic signed [CNT_W:0]    ss_offset_d;
  logic                     ss_dn_d;
  logic signed [CNT_W:0]    ss_offset_sel;
  logic signed [DIFF_W-1:0] tgt_next_c;

  // Window measurement: saturating pulse count, signed error vs sampled target, lock-counter step
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (bus.dco_pulse && (pulse_cnt_q != CNT_MAX)) pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
    diff_c     = target_eff_q - $signed({2'b00, pulse_cnt_q});
    abs_c      = diff_c[DIFF_W-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
    in_range_c = (abs_c <= {2'b00, bus.lock_tol});
    lock_cnt_d = '0;
    if (in_range_c) lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
  end

  // Correction: coarse/fine step toward the error, clamped to the code range; plus next triangle offset
  always_comb begin
    abs_q    = diff_q[DIFF_W-1] ? $unsigned(-diff_q) : $unsigned(diff_q);
    step_c   = (abs_q > THR) ? STEP_C : STEP_F;
    code_ext = $signed({2'b00, dco_code_q});
    code_sum = diff_q[DIFF_W-1] ? (code_ext - step_c) : (code_ext + step_c);
    if (code_sum[SW-1])           code_d = '0;
    else if (code_sum > CODE_MAX) code_d = '1;
    else                          code_d = code_sum[CODE_W-1:0];
    // A locked loop that is still in range leaves the code alone so dithering is not fought
    if ((diff_q == '0) || (in_range_q && fll_locked_q)) code_d = dco_code_q;
    code_chg = (code_d != dco_code_q);

    depth_s     = $signed({{(CNT_W - 7){1'b0}}, bus.ss_depth});
    ss_offset_d = ss_offset_q;
    ss_dn_d     = ss_dn_q;
    if (!(bus.ss_en && fll_locked_q) || (bus.ss_depth == 8'd0)) begin
      ss_offset_d = '0;
      ss_dn_d     = 1'b0;
    end else if (!ss_dn_q) begin
      if (ss_offset_q >= depth_s) begin
        ss_dn_d     = 1'b1;
        ss_offset_d = ss_offset_q - (CNT_W + 1)'(1);
      end else begin
        ss_offset_d = ss_offset_q + (CNT_W + 1)'(1);
      end
    end else begin
      if (ss_offset_q <= -depth_s) begin
        ss_dn_d     = 1'b0;
        ss_offset_d = ss_offset_q + (CNT_W + 1)'(1);
      end else begin
        ss_offset_d = ss_offset_q - (CNT_W + 1)'(1);
      end
    end

    // Target for the upcoming window already includes the offset written in this UPDATE
    ss_offset_sel = (state_q == S_UPDATE) ? ss_offset_d : ss_offset_q;
    tgt_next_c    = $signed({2'b00, bus.target_cnt}) + $signed({ss_offset_sel[CNT_W], ss_offset_sel});
  end

  // Loop sequencer with all state and registered outputs; reset discards any partial window
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      win_cnt_q        <= '0;
      pulse_cnt_q      <= '0;
      target_eff_q     <= '0;
      diff_q           <= '0;
      in_range_q       <= 1'b0;
      lock_cnt_q       <= '0;
      fll_locked_q     <= 1'b0;
      dco_code_q       <= CODE_RST;
      meas_cnt_q       <= '0;
      meas_valid_q     <= 1'b0;
      freq_update_q    <= 1'b0;
      freq_incr_decr_q <= 1'b0;
      ss_offset_q      <= '0;
      ss_dn_q          <= 1'b0;
    end else begin
      meas_valid_q  <= 1'b0;
      freq_update_q <= 1'b0;
      if (!bus.enable) begin
        state_q     <= S_IDLE;
        win_cnt_q   <= '0;
        pulse_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q      <= S_MEASURE;
            win_cnt_q    <= '0;
            pulse_cnt_q  <= '0;
            target_eff_q <= tgt_next_c;
          end
          S_MEASURE: begin
            pulse_cnt_q <= pulse_cnt_d;
            if (win_cnt_q == WIN_LAST) begin
              win_cnt_q <= '0;
              state_q   <= S_COMPARE;
            end else begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
            end
          end
          S_COMPARE: begin
            meas_cnt_q   <= pulse_cnt_q;
            meas_valid_q <= 1'b1;
            diff_q       <= diff_c;
            in_range_q   <= in_range_c;
            lock_cnt_q   <= lock_cnt_d;
            fll_locked_q <= (lock_cnt_d == LOCK_FULL);
            pulse_cnt_q  <= '0;
            state_q      <= S_UPDATE;
          end
          S_UPDATE: begin
            dco_code_q <= code_d;
            if (code_chg) begin
              freq_update_q    <= 1'b1;
              freq_incr_decr_q <= ~diff_q[DIFF_W-1];
            end
            ss_offset_q  <= ss_offset_d;
            ss_dn_q      <= ss_dn_d;
            target_eff_q <= tgt_next_c;
            state_q      <= S_MEASURE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dco_code       = dco_code_q;
  assign bus.meas_cnt       = meas_cnt_q;
  assign bus.meas_valid     = meas_valid_q;
  assign bus.freq_update    = freq_update_q;
  assign bus.freq_incr_decr = freq_incr_decr_q;
  assign bus.fll_locked     = fll_locked_q;
  assign bus.ss_offset      = ss_offset_q;

endmodule

// File: tb/tb_ss_freq_loop.sv
// Directed bench for ss_freq_loop: reset, coarse correction, enable drop, lock, spread spectrum, saturation.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Second instance with a long window exercises pulse-counter saturation.
module tb_ss_freq_loop;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ss_freq_loop_if #(.CNT_W(12), .CODE_W(8)) bus ();
  ss_freq_loop_if #(.CNT_W(12), .CODE_W(8)) bus2 ();

  ss_freq_loop #(.CNT_W(12), .CODE_W(8), .WIN_LEN(256)) dut (
    .ref_clk(clk), .reset(rst_n), .bus(bus)
  );
  ss_freq_loop #(.CNT_W(12), .CODE_W(8), .WIN_LEN(8192)) dut2 (
    .ref_clk(clk), .reset(rst2_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; bus.enable = 1'b0; bus.dco_pulse = 1'b0;
    repeat (3) step();
  endtask

  // Release reset with enable high: the next edge moves IDLE -> MEASURE
  task automatic start_run();
    rst_n = 1'b1; bus.enable = 1'b1;
    step();
  endtask

  // Runs one full iteration from MEASURE cycle 0; pulses also driven in COMPARE/UPDATE (must be ignored)
  task automatic run_window(input int n, input bit alt, output bit mv_ok, output bit fu_other);
    mv_ok = 1'b1; fu_other = 1'b0;
    for (int k = 0; k < 258; k++) begin
      bus.dco_pulse = (k >= 256) ? 1'b1 : (alt ? (k % 2 == 0) : (k < n));
      step();
      if (k == 256) begin
        if (bus.meas_valid !== 1'b1) mv_ok = 1'b0;
      end else if (bus.meas_valid !== 1'b0) mv_ok = 1'b0;
      if (k != 257 && bus.freq_update !== 1'b0) fu_other = 1'b1;
    end
    bus.dco_pulse = 1'b0;
  endtask

  task automatic test_reset();
    bit mv_seen;
    rst_n = 1'b0; bus.enable = 1'b1; bus.dco_pulse = 1'b1;
    repeat (3) step();
    n_tests++; if (bus.dco_code !== 8'd128) begin n_fail++; $display("FAIL rst_code got %0d want 128", bus.dco_code); end
    n_tests++; if (bus.meas_cnt !== 12'd0) begin n_fail++; $display("FAIL rst_meas got %0d want 0", bus.meas_cnt); end
    n_tests++; if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mv got %b want 0", bus.meas_valid); end
    n_tests++; if (bus.freq_update !== 1'b0) begin n_fail++; $display("FAIL rst_fu got %b want 0", bus.freq_update); end
    n_tests++; if (bus.freq_incr_decr !== 1'b0) begin n_fail++; $display("FAIL rst_fid got %b want 0", bus.freq_incr_decr); end
    n_tests++; if (bus.fll_locked !== 1'b0) begin n_fail++; $display("FAIL rst_lock got %b want 0", bus.fll_locked); end
    n_tests++; if (bus.ss_offset !== 13'sd0) begin n_fail++; $display("FAIL rst_ssoff got %0d want 0", $signed(bus.ss_offset)); end
    // Out of reset with enable low the loop must stay idle
    rst_n = 1'b1; bus.enable = 1'b0; mv_seen = 1'b0;
    repeat (300) begin step(); if (bus.meas_valid !== 1'b0) mv_seen = 1'b1; end
    n_tests++; if (mv_seen !== 1'b0) begin n_fail++; $display("FAIL idle_no_meas got %b want 0", mv_seen); end
    bus.dco_pulse = 1'b0;
  endtask

  task automatic test_coarse_down();
    bit mv_ok, fu_other;
    apply_reset();
    bus.target_cnt = 12'd100; bus.lock_tol = 12'd1; bus.ss_en = 1'b0; bus.ss_depth = 8'd0;
    start_run();
    run_window(0, 1'b1, mv_ok, fu_other);
    n_tests++; if (mv_ok !== 1'b1) begin n_fail++; $display("FAIL cd_mv_timing got %b want 1", mv_ok); end
    n_tests++; if (fu_other !== 1'b0) begin n_fail++; $display("FAIL cd_fu_early got %b want 0", fu_other); end
    n_tests++; if (bus.meas_cnt !== 12'd128) begin n_fail++; $display("FAIL cd_meas got %0d want 128", bus.meas_cnt); end
    n_tests++; if (bus.freq_update !== 1'b1) begin n_fail++; $display("FAIL cd_fu got %b want 1", bus.freq_update); end
    n_tests++; if (bus.freq_incr_decr !== 1'b0) begin n_fail++; $display("FAIL cd_fid got %b want 0", bus.freq_incr_decr); end
    n_tests++; if (bus.dco_code !== 8'd120) begin n_fail++; $display("FAIL cd_code got %0d want 120", bus.dco_code); end
  endtask

  // Follows test_coarse_down: code 120, sitting in MEASURE cycle 0
  task automatic test_enable_drop();
    bit mv_seen, mv_ok, fu_other;
    for (int k = 0; k < 100; k++) begin bus.dco_pulse = 1'b1; step(); end
    bus.enable = 1'b0;
    step();
    n_tests++; if (bus.dco_code !== 8'd120) begin n_fail++; $display("FAIL ed_code_hold got %0d want 120", bus.dco_code); end
    n_tests++; if (bus.meas_cnt !== 12'd128) begin n_fail++; $display("FAIL ed_meas_hold got %0d want 128", bus.meas_cnt); end
    mv_seen = 1'b0;
    repeat (300) begin step(); if (bus.meas_valid !== 1'b0) mv_seen = 1'b1; end
    n_tests++; if (mv_seen !== 1'b0) begin n_fail++; $display("FAIL ed_idle_meas got %b want 0", mv_seen); end
    bus.dco_pulse = 1'b0; bus.enable = 1'b1;
    step();
    run_window(128, 1'b0, mv_ok, fu_other);
    n_tests++; if (mv_ok !== 1'b1) begin n_fail++; $display("FAIL ed_mv_timing got %b want 1", mv_ok); end
    n_tests++; if (bus.meas_cnt !== 12'd128) begin n_fail++; $display("FAIL ed_meas_fresh got %0d want 128", bus.meas_cnt); end
    n_tests++; if (bus.dco_code !== 8'd112) begin n_fail++; $display("FAIL ed_code got %0d want 112", bus.dco_code); end
  endtask

  task automatic test_lock();
    bit mv_ok, fu_other, any_fu;
    apply_reset();
    bus.target_cnt = 12'd100; bus.lock_tol = 12'd1; bus.ss_en = 1'b0; bus.ss_depth = 8'd0;
    start_run();
    any_fu = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      run_window(100, 1'b0, mv_ok, fu_other);
      if (fu_other || bus.freq_update) any_fu = 1'b1;
      if (w == 3) begin
        n_tests++; if (bus.fll_locked !== 1'b0) begin n_fail++; $display("FAIL lk_early got %b want 0", bus.fll_locked); end
      end
    end
    n_tests++; if (bus.fll_locked !== 1'b1) begin n_fail++; $display("FAIL lk_rise got %b want 1", bus.fll_locked); end
    n_tests++; if (any_fu !== 1'b0) begin n_fail++; $display("FAIL lk_no_update got %b want 0", any_fu); end
    n_tests++; if (bus.dco_code !== 8'd128) begin n_fail++; $display("FAIL lk_code got %0d want 128", bus.dco_code); end
    run_window(103, 1'b0, mv_ok, fu_other);
    n_tests++; if (bus.fll_locked !== 1'b0) begin n_fail++; $display("FAIL lk_loss got %b want 0", bus.fll_locked); end
    n_tests++; if (bus.meas_cnt !== 12'd103) begin n_fail++; $display("FAIL lk_meas got %0d want 103", bus.meas_cnt); end
    n_tests++; if (bus.dco_code !== 8'd127) begin n_fail++; $display("FAIL lk_fine_code got %0d want 127", bus.dco_code); end
    n_tests++; if (bus.freq_update !== 1'b1) begin n_fail++; $display("FAIL lk_fu got %b want 1", bus.freq_update); end
    n_tests++; if (bus.freq_incr_decr !== 1'b0) begin n_fail++; $display("FAIL lk_fid got %b want 0", bus.freq_incr_decr); end
  endtask

  // Follows test_lock: relock, then reset in the middle of a window
  task automatic test_reset_mid();
    bit mv_ok, fu_other;
    for (int w = 0; w < 4; w++) run_window(100, 1'b0, mv_ok, fu_other);
    n_tests++; if (bus.fll_locked !== 1'b1) begin n_fail++; $display("FAIL rm_relock got %b want 1", bus.fll_locked); end
    for (int k = 0; k < 100; k++) begin bus.dco_pulse = 1'b1; step(); end
    rst_n = 1'b0;
    step();
    n_tests++; if (bus.dco_code !== 8'd128) begin n_fail++; $display("FAIL rm_code got %0d want 128", bus.dco_code); end
    n_tests++; if (bus.fll_locked !== 1'b0) begin n_fail++; $display("FAIL rm_lock got %b want 0", bus.fll_locked); end
    n_tests++; if (bus.meas_cnt !== 12'd0) begin n_fail++; $display("FAIL rm_meas got %0d want 0", bus.meas_cnt); end
    bus.dco_pulse = 1'b0;
  endtask

  task automatic test_spread();
    bit mv_ok, fu_other, any_fu;
    logic signed [12:0] exp_off [12];
    logic signed [12:0] e;
    exp_off = '{13'sd0, 13'sd0, 13'sd0, 13'sd1, 13'sd2, 13'sd1, 13'sd0, -13'sd1, -13'sd2, -13'sd1, 13'sd0, 13'sd1};
    apply_reset();
    bus.target_cnt = 12'd100; bus.lock_tol = 12'd4; bus.ss_en = 1'b1; bus.ss_depth = 8'd2;
    start_run();
    any_fu = 1'b0;
    for (int w = 0; w < 12; w++) begin
      run_window(100, 1'b0, mv_ok, fu_other);
      if (fu_other || bus.freq_update) any_fu = 1'b1;
      e = exp_off[w];
      n_tests++;
      if (bus.ss_offset !== e) begin
        n_fail++; $display("FAIL ss_tri_w%0d got %0d want %0d", w + 1, $signed(bus.ss_offset), e);
      end
    end
    n_tests++; if (bus.fll_locked !== 1'b1) begin n_fail++; $display("FAIL ss_locked got %b want 1", bus.fll_locked); end
    n_tests++; if (any_fu !== 1'b0) begin n_fail++; $display("FAIL ss_code_moved got %b want 0", any_fu); end
    bus.ss_en = 1'b0;
    run_window(100, 1'b0, mv_ok, fu_other);
    n_tests++; if (bus.ss_offset !== 13'sd0) begin n_fail++; $display("FAIL ss_off_disable got %0d want 0", $signed(bus.ss_offset)); end
    bus.ss_en = 1'b1; bus.ss_depth = 8'd0;
    for (int w = 0; w < 2; w++) begin
      run_window(100, 1'b0, mv_ok, fu_other);
      n_tests++; if (bus.ss_offset !== 13'sd0) begin n_fail++; $display("FAIL ss_depth0_w%0d got %0d want 0", w, $signed(bus.ss_offset)); end
    end
    bus.ss_en = 1'b0;
  endtask

  task automatic test_saturation();
    bit mv_ok, fu_other;
    apply_reset();
    bus.target_cnt = 12'd4000; bus.lock_tol = 12'd1; bus.ss_en = 1'b0; bus.ss_depth = 8'd0;
    start_run();
    for (int w = 1; w <= 17; w++) begin
      run_window(0, 1'b0, mv_ok, fu_other);
      if (w == 1) begin
        n_tests++; if (bus.dco_code !== 8'd136) begin n_fail++; $display("FAIL sat_w1_code got %0d want 136", bus.dco_code); end
      end
      if (w == 16) begin
        n_tests++; if (bus.dco_code !== 8'd255) begin n_fail++; $display("FAIL sat_clamp_code got %0d want 255", bus.dco_code); end
        n_tests++; if (bus.freq_update !== 1'b1) begin n_fail++; $display("FAIL sat_clamp_fu got %b want 1", bus.freq_update); end
        n_tests++; if (bus.freq_incr_decr !== 1'b1) begin n_fail++; $display("FAIL sat_clamp_fid got %b want 1", bus.freq_incr_decr); end
      end
    end
    n_tests++; if (bus.dco_code !== 8'd255) begin n_fail++; $display("FAIL sat_hold_code got %0d want 255", bus.dco_code); end
    n_tests++; if ((bus.freq_update | fu_other) !== 1'b0) begin n_fail++; $display("FAIL sat_hold_fu got %b want 0", bus.freq_update | fu_other); end
    run_window(256, 1'b0, mv_ok, fu_other);
    n_tests++; if (bus.meas_cnt !== 12'd256) begin n_fail++; $display("FAIL sat_full_meas got %0d want 256", bus.meas_cnt); end
    n_tests++; if (bus.freq_update !== 1'b0) begin n_fail++; $display("FAIL sat_full_fu got %b want 0", bus.freq_update); end
  endtask

  task automatic test_cnt_sat();
    bit seen;
    int cyc;
    rst2_n = 1'b0; bus2.enable = 1'b1; bus2.dco_pulse = 1'b1;
    repeat (3) step();
    rst2_n = 1'b1;
    step();
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 9000) begin
      step(); cyc++;
      if (bus2.meas_valid === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL cs_meas_valid timeout after %0d cycles", cyc); end
    n_tests++; if (cyc != 8193) begin n_fail++; $display("FAIL cs_latency got %0d want 8193", cyc); end
    n_tests++; if (bus2.meas_cnt !== 12'd4095) begin n_fail++; $display("FAIL cs_meas got %0d want 4095", bus2.meas_cnt); end
    bus2.enable = 1'b0; bus2.dco_pulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    bus.enable = 1'b0; bus.dco_pulse = 1'b0; bus.target_cnt = 12'd100; bus.lock_tol = 12'd1;
    bus.ss_en = 1'b0; bus.ss_depth = 8'd0;
    bus2.enable = 1'b0; bus2.dco_pulse = 1'b0; bus2.target_cnt = 12'd100; bus2.lock_tol = 12'd1;
    bus2.ss_en = 1'b0; bus2.ss_depth = 8'd0;
    test_reset();
    test_coarse_down();
    test_enable_drop();
    test_lock();
    test_reset_mid();
    test_spread();
    test_saturation();
    test_cnt_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ss_freq_loop.md
SS_FREQ_LOOP -- requirements
Module: ss_freq_loop

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CNT_W, 12: measurement counter and target width.
- CODE_W, 8: DCO control code width.
- WIN_LEN, 256: ref_clk cycles per measurement window.
- LOCK_WINS, 4: consecutive in-range windows required to declare lock.
- COARSE_THR, 16: |diff| above which the coarse step applies.
- COARSE_STEP, 8: coarse code step; the fine step is 1.
- CODE_INIT, 2^(CODE_W-1): dco_code value after reset.
REQ-002 Ports, one per line: name, direction, width, meaning.
- ref_clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-low reset.
- enable, in, 1: loop run enable.
- dco_pulse, in, 1: one-cycle pulse per divided-DCO edge, already synchronised to ref_clk.
- target_cnt, in, CNT_W: desired pulses per window.
- lock_tol, in, CNT_W: allowed |diff| for the in-range condition.
- ss_en, in, 1: spread-spectrum enable.
- ss_depth, in, 8: triangle amplitude in counts.
- dco_code, out, CODE_W: DCO switch code.
- meas_cnt, out, CNT_W: last completed window count.
- meas_valid, out, 1: one-cycle pulse when meas_cnt updates.
- freq_update, out, 1: one-cycle pulse when dco_code changes.
- freq_incr_decr, out, 1: 1 = code incremented, 0 = decremented; valid with freq_update.
- fll_locked, out, 1: lock status.
- ss_offset, out, CNT_W+1 signed: current target offset.

Function
REQ-003 FSM states: IDLE, MEASURE, COMPARE, UPDATE.
- IDLE -> MEASURE when enable=1.
- MEASURE -> COMPARE after WIN_LEN cycles.
- COMPARE -> UPDATE after 1 cycle.
- UPDATE -> MEASURE after 1 cycle.
- One iteration = WIN_LEN+2 cycles.
REQ-004 enable=0 in any state SHALL force IDLE on the next cycle; window counter and pulse counter clear; dco_code, meas_cnt, fll_locked and ss_offset hold.
REQ-005 On MEASURE entry: target_eff = target_cnt + ss_offset, sampled once; target_cnt changes mid-window take effect in the next window.
REQ-006 Pulse counting:
- Counts every dco_pulse=1 cycle in MEASURE, including the last MEASURE cycle.
- Saturates at 2^CNT_W-1.
- Pulses during IDLE/COMPARE/UPDATE are ignored.
REQ-007 COMPARE cycle:
- meas_cnt <= count; meas_valid pulses.
- diff = target_eff - count, signed CNT_W+2 bits, no wrap.
- in_range = |diff| <= lock_tol.
REQ-008 UPDATE cycle, when diff != 0:
- step = COARSE_STEP if |diff| > COARSE_THR, else 1.
- diff > 0: code += step; diff < 0: code -= step.
- Result saturates to [0, 2^CODE_W-1].
- No change when in_range=1 and fll_locked=1.
REQ-009 freq_update pulses in the UPDATE cycle only if dco_code actually changes; at a saturation limit it stays 0.
REQ-010 Lock counter:
- in_range increments it, saturating at LOCK_WINS; not in_range clears it to 0.
- fll_locked = (counter == LOCK_WINS), registered at COMPARE.
- Loss of range deasserts fll_locked in the same COMPARE.
REQ-011 Spread spectrum, active only when ss_en=1 and fll_locked=1:
- ss_offset steps by 1 at each UPDATE as a triangle 0 -> +ss_depth -> -ss_depth -> 0, repeating; direction reverses on reaching ±ss_depth.
- Otherwise ss_offset <= 0 at UPDATE, direction resets to up.
- ss_depth=0 gives constant 0.
REQ-012 A dco_code change and a lock transition in the same iteration are both applied; no priority conflict exists.

Reset
REQ-013 While reset=0 at a ref_clk edge:
- state IDLE, dco_code=CODE_INIT, ss_offset=0, direction up.
- meas_cnt=0, meas_valid=0, freq_update=0, freq_incr_decr=0, fll_locked=0, all counters 0.
REQ-014 Reset SHALL override enable and any state, including mid-window; the partial window is discarded.

Verification
REQ-015 Reset: hold reset=0 3 cycles with enable=1 -> dco_code=128, all other outputs 0, IDLE.
REQ-016 Coarse down: target=100, tol=1, dco_pulse every 2nd cycle (128/window) -> meas_cnt=128, diff=-28; dco_code 128->120; freq_update=1 with freq_incr_decr=0, 258 cycles after MEASURE entry.
REQ-017 Lock: 100 pulses per window, target=100, tol=1 -> no code change; fll_locked rises at the 4th COMPARE; a 103-pulse window then clears it and code goes +... (diff=-3 -> code-1, freq_incr_decr=0).
REQ-018 Spread spectrum: locked, ss_en=1, ss_depth=2 -> successive ss_offset 1,2,1,0,-1,-2,-1,0,1; ss_en=0 -> 0 at the next UPDATE.
REQ-019 Saturation: dco_code=255, no dco_pulse, target=4000 -> code stays 255, freq_update=0; continuous pulses -> meas_cnt=256 (WIN_LEN); counter saturation checked with WIN_LEN=8192 -> 4095.
REQ-020 Mid-operation: enable=0 at window cycle 100 -> IDLE next cycle, dco_code held; reset=0 at cycle 100 -> dco_code=128, fll_locked=0.
